// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor front end: opcode map,
// dispatcher FSM encoding and the opcode screening helper.
package coproc_pkg;

  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_SUM    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_MUL    = 4'd5;
  localparam logic [3:0] OP_TRANSP = 4'd6;
  localparam logic [3:0] OP_OPST   = 4'd7;
  localparam logic [3:0] OP_MULSCL = 4'd8;
  localparam logic [3:0] OP_DET2   = 4'd9;
  localparam logic [3:0] OP_DET3   = 4'd10;
  localparam logic [3:0] OP_DET4   = 4'd11;
  localparam logic [3:0] OP_DET5   = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Opcodes form one contiguous legal range; 0 and 13..15 are reserved.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_READ) && (op <= OP_DET5);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// read/write pointers wrap without extra compare logic.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_dispatcher.sv
// Two-port round-robin front end for the matrix coprocessor: screens opcodes,
// queues instructions and issues them one at a time, with a hang timeout.
module instr_dispatcher import coproc_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [31:0]              req0_instr,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [31:0]              req1_instr,
  output logic                     req1_ready,
  output logic [31:0]              cop_instruction,
  output logic                     cop_activate,
  input  logic                     cop_idle,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              done_count,
  output logic                     err_opcode,
  output logic                     err_timeout,
  input  logic                     err_clear,
  output logic [1:0]               dbg_state
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  // Handshake: a word moves on a rising edge where reqN_valid && reqN_ready.
  // Ready is the grant gated by the registered full flag, so a full FIFO
  // refuses every push even if the FSM pops on the same edge.
  logic        ptr_q;
  logic        grant0;
  logic        grant1;
  logic        xfer0;
  logic        xfer1;
  logic [31:0] xfer_instr;
  logic        xfer_legal;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;

  state_t        state_q;
  logic [31:0]   instr_q;
  logic          activate_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          timed_out;
  logic [15:0]   done_count_q;
  logic          err_opcode_q;
  logic          err_timeout_q;
  logic          opcode_evt;
  logic          timeout_evt;

  assign grant0     = req0_valid && (!ptr_q || !req1_valid);
  assign grant1     = req1_valid && !grant0;
  assign req0_ready = grant0 && !fifo_full;
  assign req1_ready = grant1 && !fifo_full;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer_instr = xfer1 ? req1_instr : req0_instr;
  assign xfer_legal = is_legal_op(xfer_instr[3:0]);
  assign fifo_push  = (xfer0 || xfer1) && xfer_legal;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign opcode_evt = (xfer0 || xfer1) && !xfer_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (xfer0 || xfer1) begin
      ptr_q <= ~ptr_q;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (xfer_instr),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Timer counts cycles spent in ISSUE+WAIT including the current one, so an
  // abort lands on the edge closing the TIMEOUT-th cycle.
  assign timer_d   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  assign timed_out = (timer_d == TIMEOUT_C);

  assign timeout_evt = timed_out &&
                       (((state_q == ISSUE) && cop_idle) ||
                        ((state_q == WAIT) && !cop_idle));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      activate_q   <= 1'b0;
      timer_q      <= '0;
      done_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            instr_q    <= fifo_head;
            timer_q    <= '0;
            activate_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= timer_d;
          if (!cop_idle) begin
            activate_q <= 1'b0;
            state_q    <= WAIT;
          end else if (timed_out) begin
            activate_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        WAIT: begin
          timer_q <= timer_d;
          if (cop_idle) begin
            done_count_q <= done_count_q + 1'b1;
            state_q      <= IDLE;
          end else if (timed_out) begin
            state_q <= IDLE;
          end
        end
        default: begin
          activate_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // A new error event in the same cycle as err_clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (opcode_evt) begin
        err_opcode_q <= 1'b1;
      end else if (err_clear) begin
        err_opcode_q <= 1'b0;
      end
      if (timeout_evt) begin
        err_timeout_q <= 1'b1;
      end else if (err_clear) begin
        err_timeout_q <= 1'b0;
      end
    end
  end

  assign cop_instruction = instr_q;
  assign cop_activate    = activate_q;
  assign busy            = (state_q != IDLE) || !fifo_empty;
  assign done_count      = done_count_q;
  assign err_opcode      = err_opcode_q;
  assign err_timeout     = err_timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: opcode table plus hand-written
// sequences for arbitration, timeout, asynchronous reset and counter wrap.
module tb_instr_dispatcher;

  localparam int CORE_AUTO = 0;
  localparam int CORE_HIGH = 1;
  localparam int CORE_LOW  = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_instr;
  logic        req1_ready;
  logic [31:0] cop_instruction;
  logic        cop_activate;
  logic        cop_idle;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] done_count;
  logic        err_opcode;
  logic        err_timeout;
  logic        err_clear;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  int core_mode   = CORE_AUTO;
  int core_cycles = 10;
  int core_left   = 0;
  logic act_prev  = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic        exp_err;
    logic [15:0] exp_done;
  } op_vec_t;

  op_vec_t vecs[8];

  instr_dispatcher #(
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_instr      (req0_instr),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_instr      (req1_instr),
    .req1_ready      (req1_ready),
    .cop_instruction (cop_instruction),
    .cop_activate    (cop_activate),
    .cop_idle        (cop_idle),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .done_count      (done_count),
    .err_opcode      (err_opcode),
    .err_timeout     (err_timeout),
    .err_clear       (err_clear),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Core model: auto mode leaves FETCH one step after seeing the strobe and
  // returns after core_cycles cycles; the other modes pin cop_idle.
  initial begin
    cop_idle = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (core_mode)
        CORE_HIGH: cop_idle = 1'b1;
        CORE_LOW:  cop_idle = 1'b0;
        default: begin
          if (cop_idle) begin
            if (cop_activate) begin
              cop_idle  = 1'b0;
              core_left = core_cycles;
            end
          end else begin
            core_left--;
            if (core_left <= 0) cop_idle = 1'b1;
          end
        end
      endcase
    end
  end

  // Scoreboard: every new issue must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && cop_activate && !act_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got 0x%08h, expected no issue", cop_instruction);
      end else begin
        chk("issue_order", cop_instruction, exp_q.pop_front());
      end
    end
    act_prev = cop_activate;
  end

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    err_clear  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send(input int port, input logic [31:0] w);
    int i;
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1'b1;
      req0_instr = w;
    end else begin
      req1_valid = 1'b1;
      req1_instr = w;
    end
    for (i = 0; i < 20; i++) begin
      #1;
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) break;
      @(negedge clk);
    end
    if (i == 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: port %0d never ready for 0x%08h", port, w);
    end else begin
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_not_busy(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int n1;
    int k;
    int port;
    int cnt;
    logic [31:0] w0;
    logic [31:0] w1;

    vecs[0] = '{32'h0000_0000, 1'b1, 16'd0};
    vecs[1] = '{32'h0000_0001, 1'b0, 16'd1};
    vecs[2] = '{32'hABCD_000C, 1'b0, 16'd2};
    vecs[3] = '{32'h0000_000D, 1'b1, 16'd2};
    vecs[4] = '{32'h0000_000F, 1'b1, 16'd2};
    vecs[5] = '{32'h0000_0005, 1'b0, 16'd3};
    vecs[6] = '{32'h1234_5670, 1'b1, 16'd3};
    vecs[7] = '{32'hFFFF_FFF8, 1'b0, 16'd4};

    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_instr = '0;
    req1_instr = '0;
    err_clear  = 1'b0;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    chk("rst_instr", cop_instruction, 32'h0);
    chk("rst_activate", {31'h0, cop_activate}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_fifo_count", {28'h0, fifo_count}, 32'h0);
    chk("rst_done", {16'h0, done_count}, 32'h0);
    chk("rst_err_opcode", {31'h0, err_opcode}, 32'h0);
    chk("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;

    // Single instruction with issue latency
    core_mode   = CORE_AUTO;
    core_cycles = 10;
    exp_q.push_back(32'h0000_0003);
    send(0, 32'h0000_0003);
    @(negedge clk);
    chk("single_act_n1", {31'h0, cop_activate}, 32'h0);
    chk("single_count_n1", {28'h0, fifo_count}, 32'h1);
    @(negedge clk);
    chk("single_act_n2", {31'h0, cop_activate}, 32'h1);
    chk("single_count_n2", {28'h0, fifo_count}, 32'h0);
    chk("single_busy_n2", {31'h0, busy}, 32'h1);
    chk("single_instr", cop_instruction, 32'h0000_0003);
    wait_not_busy("single_wait", 40);
    chk("single_done", {16'h0, done_count}, 32'h1);
    chk("single_act_after", {31'h0, cop_activate}, 32'h0);
    chk("single_instr_hold", cop_instruction, 32'h0000_0003);

    // Opcode screening table
    core_cycles = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_pulse();
      chk("tbl_err_cleared", {31'h0, err_opcode}, 32'h0);
      if (!vecs[i].exp_err) exp_q.push_back(vecs[i].instr);
      send(i % 2, vecs[i].instr);
      @(negedge clk);
      chk("tbl_err_opcode", {31'h0, err_opcode}, {31'h0, vecs[i].exp_err});
      wait_not_busy("tbl_wait", 40);
      chk("tbl_done", {16'h0, done_count}, {16'h0, vecs[i].exp_done});
    end

    // Error set beats a simultaneous clear
    err_clear = 1'b1;
    send(0, 32'h0000_000E);
    err_clear = 1'b0;
    @(negedge clk);
    chk("set_wins_clear", {31'h0, err_opcode}, 32'h1);
    chk("illegal_not_queued", {28'h0, fifo_count}, 32'h0);
    clear_pulse();
    chk("clear_after_set", {31'h0, err_opcode}, 32'h0);

    // Round-robin contention with the core stalled
    core_mode = CORE_LOW;
    do_reset();
    n0 = 0;
    n1 = 0;
    k  = 0;
    for (int c = 0; c < 30 && k < 9; c++) begin
      @(negedge clk);
      w0 = {20'h0, 8'(n0), 4'h3};
      w1 = {20'h0, 8'(n1), 4'h4};
      req0_valid = 1'b1;
      req0_instr = w0;
      req1_valid = 1'b1;
      req1_instr = w1;
      #1;
      if (k == 2 && c == 2) chk("push_pop_same_edge", {28'h0, fifo_count}, 32'h1);
      if (req0_ready && req1_ready) begin
        chk("rr_single_grant", 32'h1, 32'h0);
      end else if (req0_ready || req1_ready) begin
        port = req1_ready ? 1 : 0;
        chk("rr_port", port, k % 2);
        exp_q.push_back(port == 1 ? w1 : w0);
        @(posedge clk);
        if (port == 1) n1++;
        else n0++;
        k++;
      end
    end
    @(negedge clk);
    #1;
    chk("rr_transfers", k, 9);
    chk("rr_ready0_full", {31'h0, req0_ready}, 32'h0);
    chk("rr_ready1_full", {31'h0, req1_ready}, 32'h0);
    chk("rr_count_full", {28'h0, fifo_count}, 32'h8);
    chk("rr_state_wait", {30'h0, dbg_state}, 32'h2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    core_cycles = 2;
    core_mode   = CORE_AUTO;
    wait_not_busy("rr_drain", 600);
    chk("rr_done", {16'h0, done_count}, 32'd9);
    chk("rr_all_issued", exp_q.size(), 32'h0);
    chk("rr_no_timeout", {31'h0, err_timeout}, 32'h0);

    // Timeout with cop_idle stuck high
    core_mode = CORE_HIGH;
    do_reset();
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0002);
    send(0, 32'h0000_0001);
    send(1, 32'h0000_0002);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cop_activate) cnt++;
      else break;
    end
    chk("to_issue_cycles", cnt, 16);
    chk("to_err_set", {31'h0, err_timeout}, 32'h1);
    chk("to_done_zero", {16'h0, done_count}, 32'h0);
    chk("to_next_queued", {28'h0, fifo_count}, 32'h1);
    @(negedge clk);
    chk("to_next_issued", {31'h0, cop_activate}, 32'h1);
    wait_not_busy("to_wait", 60);
    chk("to_done_still_zero", {16'h0, done_count}, 32'h0);
    clear_pulse();
    chk("to_err_cleared", {31'h0, err_timeout}, 32'h0);

    // Asynchronous reset while in WAIT with entries queued
    core_mode = CORE_LOW;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'h0000_1000 | i);
      send(0, 32'h0000_1000 | i);
    end
    @(negedge clk);
    chk("mid_state_wait", {30'h0, dbg_state}, 32'h2);
    chk("mid_count", {28'h0, fifo_count}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_instr", cop_instruction, 32'h0);
    chk("async_activate", {31'h0, cop_activate}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_count", {28'h0, fifo_count}, 32'h0);
    chk("async_done", {16'h0, done_count}, 32'h0);
    chk("async_state", {30'h0, dbg_state}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    core_mode = CORE_AUTO;
    @(negedge clk);
    rst_n = 1'b1;

    // done_count wrap
    core_cycles = 2;
    do_reset();
    @(negedge clk);
    force dut.done_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.done_count_q;
    @(negedge clk);
    chk("wrap_preload", {16'h0, done_count}, 32'h0000_FFFF);
    exp_q.push_back(32'h0000_0007);
    send(1, 32'h0000_0007);
    wait_not_busy("wrap_wait", 40);
    chk("wrap_done", {16'h0, done_count}, 32'h0);
    chk("final_all_issued", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
# instr_dispatcher

Buffers 32-bit coprocessor instructions from two host-side requesters (HPS bridge on port 0, debug/test port on port 1), arbitrates between them round-robin, and sequences them one at a time into the matrix coprocessor core's `instruction`/`activate_instruction` inputs. It waits for the core to return to its fetch state before issuing the next instruction. It screens opcodes, times out hung operations, and counts retired instructions.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT`, 4095: maximum cycles spent in ISSUE or WAIT before abort.
- `clk` in 1: single clock; every flop is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1 / `req0_instr` in 32 / `req0_ready` out 1: requester 0 valid/ready handshake.
- `req1_valid` in 1 / `req1_instr` in 32 / `req1_ready` out 1: requester 1 valid/ready handshake.
- `cop_instruction` out 32: instruction presented to the core.
- `cop_activate` out 1: issue strobe to the core.
- `cop_idle` in 1: high while the core sits in FETCH.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.
- `done_count` out 16: retired instructions; wraps at 0xFFFF to 0.
- `err_opcode` out 1: sticky flag; an illegal opcode was dropped.
- `err_timeout` out 1: sticky flag; an instruction was aborted.
- `err_clear` in 1: synchronous clear of both sticky flags.

## Operation
- **Opcode field:** `instr[3:0]`.
  - Legal values are 1 through 12 (READ, WRITE, SUM, SUB, MUL, TRANSP, OPST, MULSCL, DET2 through DET5).
  - Values 0 and 13 through 15 are illegal.
- **Arbitration:**
  - At most one requester is granted per cycle.
  - The priority pointer toggles after every accepted transfer.
  - A lone valid requester is granted regardless of the pointer.
  - `reqN_ready` = granted & !full, combinational from registered state only. It must not depend on `reqN_valid` of the other port beyond grant selection.
  - A transfer occurs when valid & ready are high at the edge.
  - A full FIFO blocks all pushes, even when a pop happens in the same cycle.
- **Illegal opcode:** the transfer is accepted (ready high) but the word is not pushed, and `err_opcode` is set.
- **FSM states and transitions:**
  - IDLE: if the FIFO is non-empty, pop the head into the `cop_instruction` register, clear the timer, and go to ISSUE.
  - ISSUE: `cop_activate` = 1. If `cop_idle` = 0, the core has accepted; go to WAIT. If the timer reaches TIMEOUT, go to IDLE and set `err_timeout`.
  - WAIT: `cop_activate` = 0. If `cop_idle` = 1, increment `done_count` and go to IDLE. If the timer reaches TIMEOUT, go to IDLE, set `err_timeout`, and leave `done_count` unchanged.
- `cop_instruction` is stable from the pop until the next pop.
- **Sticky flags:**
  - If `err_clear` is asserted in the same cycle as a new error event, the set wins.
- **Reset (asynchronous):**
  - FSM goes to IDLE and the FIFO is emptied.
  - Pointer selects requester 0.
  - Outputs: `cop_instruction` 0, `cop_activate` 0, `busy` 0, `fifo_count` 0, `done_count` 0, both error flags 0.
  - An instruction in flight is abandoned; the core is not notified.

## Timing
- **Issue latency:** a push at edge N into an empty FIFO with the FSM in IDLE gives:
  - pop at edge N+1;
  - `cop_activate` high during cycle N+2.
- `cop_activate` is held for at least 1 cycle, until the edge at which `cop_idle` = 0 is sampled.
- **Completion:** `done_count` updates at the edge where WAIT samples `cop_idle` = 1. The next pop happens one cycle later at the earliest.
- **Back-to-back throughput:** with `core_cycles` counting cycles while the core is away from FETCH, one instruction takes at least 3 + `core_cycles` cycles.
- **Timer:** 12+ bits and saturating. Abort happens on the edge where the count equals TIMEOUT.
- **Push/pop in the same cycle:** `fifo_count` is unchanged (only possible when the FIFO is not full).

## Structure
- **Shared package `coproc_pkg`:**
  - opcode constants (READ = 4'b0001 through DET5 = 4'b1100);
  - FSM state encodings IDLE, ISSUE, WAIT;
  - an `is_legal_op` function.
- **Sub-module `sync_fifo`:**
  - parameters WIDTH and DEPTH;
  - push, pop, full, empty and count;
  - asynchronous active-low reset.
- Arbiter, FSM, timer and counters live in `instr_dispatcher`.

## Test plan
- **Single instruction:** push 0x0000_0003 on port 0; model the core dropping `cop_idle` 1 cycle after activate and raising it 10 cycles later. Required: `cop_activate` high 2 cycles after the push, `done_count` = 1, `busy` = 0 afterwards.
- **Round-robin contention:** both ports hold valid continuously with opcodes 3 and 4, core stalled. Required: FIFO order is 0,1,0,1,…; once 8 entries are held, both readys go low and `fifo_count` = 8.
- **Illegal opcode:** push 0x0000_000F then 0x0000_0005. Required: only 0x5 is issued, `err_opcode` = 1, and `err_clear` returns it to 0.
- **Timeout:** TIMEOUT = 16 with `cop_idle` stuck high. Required: abort at the 16th ISSUE cycle, `err_timeout` = 1, `done_count` = 0, next entry issued.
- **Reset mid-WAIT:** assert `rst_n` low while in WAIT with 3 entries queued. Required: all outputs at reset values immediately (asynchronous), and `fifo_count` = 0.
- **Counter wrap:** preload `done_count` to 0xFFFF via a bench force, then retire one instruction. Required: `done_count` = 0x0000.
